// File: rtl/nand_flash_ctrl_if.sv
// Host command/response and flash-array bus for nand_flash_ctrl.
// master = host plus memory environment, slave = controller.
interface nand_flash_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       wp_n;
  logic       rsp_valid;
  logic       rsp_err;
  logic [7:0] rsp_rdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, wp_n, mem_rdata,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata,
           mem_we, mem_re, mem_addr, mem_wdata
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, wp_n, mem_rdata,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata,
           mem_we, mem_re, mem_addr, mem_wdata
  );
endinterface

// File: rtl/nand_flash_ctrl.sv
// NAND-style flash controller: byte read, 1->0-only program, block erase to FF.
// Every output is a register; the array returns read data one cycle after mem_re.
module nand_flash_ctrl #(
  parameter int BLK_LOG2 = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  nand_flash_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_PROGRAM = 2'd1,
    OP_ERASE   = 2'd2,
    OP_RSVD    = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT, PG_READ, PG_WAIT, PG_WRITE, ER_WRITE, RESP
  } state_e;

  localparam logic [BLK_LOG2-1:0] CNT_ZERO = '0;
  localparam logic [BLK_LOG2-1:0] CNT_LAST = '1;

  state_e              state_q;
  logic [7:0]          addr_q;
  logic [7:0]          wdata_q;
  logic [BLK_LOG2-1:0] cnt_q;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic [7:0]          rsp_rdata_q;
  logic                mem_we_q;
  logic                mem_re_q;
  logic [7:0]          mem_addr_q;
  logic [7:0]          mem_wdata_q;

  logic [BLK_LOG2-1:0] cnt_d;
  logic [7:0]          er_addr_d;
  logic                prog_bad;
  op_e                 op;

  assign op        = op_e'(bus.cmd_op);
  assign cnt_d     = cnt_q + BLK_LOG2'(1);
  // Erase addresses keep the latched block bits, so the sweep never leaves it.
  assign er_addr_d = {addr_q[7:BLK_LOG2], cnt_d};
  assign prog_bad  = |(~bus.mem_rdata & wdata_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      // NOTE: non-blocking throughout; these pulse defaults are simply
      // overridden by any later assignment in the same edge.
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;

      unique case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (bus.cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            addr_q      <= bus.cmd_addr;
            wdata_q     <= bus.cmd_wdata;
            cnt_q       <= '0;
            if (op == OP_READ || (op == OP_PROGRAM && bus.wp_n)) begin
              state_q    <= (op == OP_READ) ? RD_ISSUE : PG_READ;
              mem_re_q   <= 1'b1;
              mem_addr_q <= bus.cmd_addr;
            end else if (op == OP_ERASE && bus.wp_n) begin
              state_q     <= ER_WRITE;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= 8'hFF;
              mem_addr_q  <= {bus.cmd_addr[7:BLK_LOG2], CNT_ZERO};
            end else begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end
          end
        end
        RD_ISSUE: state_q <= RD_WAIT;
        RD_WAIT: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= bus.mem_rdata;
        end
        PG_READ: state_q <= PG_WAIT;
        PG_WAIT: begin
          if (prog_bad) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end else begin
            state_q     <= PG_WRITE;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= addr_q;
            mem_wdata_q <= bus.mem_rdata & wdata_q;
          end
        end
        PG_WRITE: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
        end
        ER_WRITE: begin
          if (cnt_q == CNT_LAST) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q       <= cnt_d;
            mem_we_q    <= 1'b1;
            mem_wdata_q <= 8'hFF;
            mem_addr_q  <= er_addr_d;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_nand_flash_ctrl.sv
// Randomized bench for nand_flash_ctrl: a byte-array flash model on the mem bus
// and a command-level reference model of what each command should do.
module tb_nand_flash_ctrl;
  localparam int B = 4;
  localparam int N = 1 << B;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nand_flash_ctrl_if bus ();
  nand_flash_ctrl #(.BLK_LOG2(B)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0] fmem    [256];
  logic [7:0] ref_mem [256];
  int checks = 0;
  int errors = 0;

  // Flash array environment: registered read, write on the clock edge.
  always @(posedge clk) begin
    if (bus.mem_we) fmem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= fmem[bus.mem_addr];
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [28:0] all_outs();
    return {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata,
            bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata};
  endfunction

  task automatic do_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] wd,
                        input logic wp, input bit junk, output int wait_cyc);
    int exp_lat;
    int cyc;
    bit got;
    logic exp_err, got_err;
    logic [7:0] exp_rd, got_rd, base, old;
    logic [15:0] exp_w[$];
    logic [15:0] got_w[$];
    logic [7:0]  exp_r[$];
    logic [7:0]  got_r[$];
    exp_rd = 8'h00; exp_err = 1'b0; exp_lat = 1;
    got = 0; got_err = 1'b0; got_rd = 8'h00;
    base = a & ~8'(N - 1);
    case (op)
      2'd0: begin exp_lat = 3; exp_rd = ref_mem[a]; exp_r.push_back(a); end
      2'd1: begin
        if (!wp) exp_err = 1'b1;
        else begin
          old = ref_mem[a];
          exp_r.push_back(a);
          if ((~old & wd) != 8'h00) begin exp_lat = 3; exp_err = 1'b1; end
          else begin exp_lat = 4; exp_w.push_back({a, old & wd}); end
        end
      end
      2'd2: begin
        if (!wp) exp_err = 1'b1;
        else begin
          exp_lat = N + 1;
          for (int i = 0; i < N; i++) exp_w.push_back({8'(base + i), 8'hFF});
        end
      end
      default: exp_err = 1'b1;
    endcase

    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_wdata = wd; bus.wp_n = wp;
    wait_cyc = 0;
    while (!bus.cmd_ready && wait_cyc < 50) begin @(negedge clk); wait_cyc++; end
    checks++;
    if (!bus.cmd_ready) begin
      errors++;
      $display("FAIL accept_timeout op=%0d addr=%02h: cmd_ready stayed 0", op, a);
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    cyc = 0;
    while (!got && cyc < exp_lat + 20) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_we) got_w.push_back({bus.mem_addr, bus.mem_wdata});
      if (bus.mem_re) got_r.push_back(bus.mem_addr);
      checks++;
      if ((bus.mem_we && bus.mem_re) || bus.cmd_ready !== 1'b0 ||
          (!bus.mem_we && !bus.mem_re && (bus.mem_addr !== 8'h00 || bus.mem_wdata !== 8'h00))) begin
        errors++;
        $display("FAIL busy_bus op=%0d cyc=%0d: we=%b re=%b ready=%b addr=%02h wdata=%02h",
                 op, cyc, bus.mem_we, bus.mem_re, bus.cmd_ready, bus.mem_addr, bus.mem_wdata);
      end
      if (bus.rsp_valid) begin got = 1; got_err = bus.rsp_err; got_rd = bus.rsp_rdata; end
      if (got || !junk) bus.cmd_valid = 1'b0;
      else begin bus.cmd_valid = 1'b1; bus.cmd_op = 2'd2; bus.cmd_addr = ~a; bus.wp_n = 1'b1; end
    end
    bus.cmd_valid = 1'b0;

    checks++;
    if (!got || cyc != exp_lat) begin
      errors++;
      $display("FAIL latency op=%0d addr=%02h: got rsp=%0d at cycle %0d, expected cycle %0d", op, a, got, cyc, exp_lat);
    end
    checks++;
    if (got_err !== exp_err || got_rd !== exp_rd) begin
      errors++;
      $display("FAIL response op=%0d addr=%02h: err=%b rdata=%02h, expected err=%b rdata=%02h",
               op, a, got_err, got_rd, exp_err, exp_rd);
    end
    checks++;
    if (got_w.size() != exp_w.size() || got_r.size() != exp_r.size()) begin
      errors++;
      $display("FAIL access_count op=%0d addr=%02h: writes=%0d reads=%0d, expected writes=%0d reads=%0d",
               op, a, got_w.size(), got_r.size(), exp_w.size(), exp_r.size());
    end else begin
      foreach (exp_w[i]) begin
        checks++;
        if (got_w[i] !== exp_w[i]) begin
          errors++;
          $display("FAIL write_%0d op=%0d: addr/data=%04h, expected %04h", i, op, got_w[i], exp_w[i]);
        end
      end
      foreach (exp_r[i]) begin
        checks++;
        if (got_r[i] !== exp_r[i]) begin
          errors++;
          $display("FAIL read_addr op=%0d: %02h, expected %02h", op, got_r[i], exp_r[i]);
        end
      end
    end
    foreach (exp_w[i]) ref_mem[exp_w[i][15:8]] = exp_w[i][7:0];
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_addr = 8'h00; bus.cmd_wdata = 8'h00; bus.wp_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'($urandom);
      fmem[i]    = ref_mem[i];
    end
    repeat (3) @(negedge clk);
    checks++;
    if (all_outs() !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs: %08h, expected 00000000", all_outs());
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: %b, expected 1", bus.cmd_ready);
    end
  endtask

  task automatic test_directed();
    int w;
    do_cmd(2'd2, 8'h10, 8'h00, 1'b1, 0, w);
    do_cmd(2'd0, 8'h13, 8'h00, 1'b1, 0, w);
    do_cmd(2'd1, 8'h13, 8'hAB, 1'b1, 0, w);
    do_cmd(2'd0, 8'h13, 8'h00, 1'b1, 0, w);
    do_cmd(2'd1, 8'h13, 8'hFF, 1'b1, 0, w);
    do_cmd(2'd0, 8'h13, 8'h00, 1'b1, 0, w);
    do_cmd(2'd1, 8'h13, 8'h03, 1'b1, 0, w);
    do_cmd(2'd0, 8'h13, 8'h00, 1'b1, 0, w);
    checks++;
    if (fmem[8'h13] !== 8'h03 || fmem[8'h10] !== 8'hFF || fmem[8'h1F] !== 8'hFF) begin
      errors++;
      $display("FAIL directed_array: [10]=%02h [13]=%02h [1F]=%02h, expected FF 03 FF",
               fmem[8'h10], fmem[8'h13], fmem[8'h1F]);
    end
    do_cmd(2'd2, 8'h20, 8'h00, 1'b0, 0, w);
    do_cmd(2'd1, 8'h21, 8'h00, 1'b0, 0, w);
    do_cmd(2'd3, 8'h44, 8'h00, 1'b1, 0, w);
  endtask

  task automatic test_ignore_busy();
    int w;
    do_cmd(2'd0, 8'($urandom), 8'h00, 1'b1, 1, w);
    do_cmd(2'd1, 8'h13, 8'h01, 1'b1, 1, w);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_re !== 1'b0) begin
        errors++;
        $display("FAIL ignore_busy: ready=%b rsp=%b we=%b re=%b, expected 1 0 0 0",
                 bus.cmd_ready, bus.rsp_valid, bus.mem_we, bus.mem_re);
      end
    end
  endtask

  task automatic test_back_to_back();
    int w;
    for (int i = 0; i < 6; i++) begin
      do_cmd(2'(i % 4), 8'($urandom), 8'h00, 1'b1, 0, w);
      checks++;
      if (w != 0) begin
        errors++;
        $display("FAIL back_to_back_%0d: accepted after %0d idle cycles, expected 0", i, w);
      end
    end
  endtask

  task automatic test_reset_mid_erase();
    int w;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd2; bus.cmd_addr = 8'h30; bus.wp_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (all_outs() !== 29'd0) begin
      errors++;
      $display("FAIL async_reset_outputs: %08h, expected 00000000", all_outs());
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.mem_we !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: rsp=%b we=%b, expected 0 0", bus.rsp_valid, bus.mem_we);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) ref_mem[8'h30 + i] = 8'hFF;
    do_cmd(2'd0, 8'h36, 8'h00, 1'b1, 0, w);
    do_cmd(2'd0, 8'h34, 8'h00, 1'b1, 0, w);
    do_cmd(2'd0, 8'h35, 8'h00, 1'b1, 0, w);
    do_cmd(2'd0, 8'h30, 8'h00, 1'b1, 0, w);
  endtask

  task automatic test_random();
    int w;
    logic [1:0] op;
    logic [7:0] a, wd;
    logic wp;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = 8'($urandom);
      wp = ($urandom_range(0, 7) != 0);
      wd = ($urandom_range(0, 1) != 0) ? (ref_mem[a] & 8'($urandom)) : 8'($urandom);
      do_cmd(op, a, wd, wp, bit'($urandom_range(0, 1)), w);
    end
    for (int i = 0; i < 256; i++) begin
      if (fmem[i] !== ref_mem[i]) begin
        checks++;
        errors++;
        $display("FAIL final_array[%02h]: %02h, expected %02h", i, fmem[i], ref_mem[i]);
      end
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_erase();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nand_flash_ctrl.md
NAND_FLASH_CTRL -- requirements
Module: nand_flash_ctrl

Interface
REQ-001 Parameter BLK_LOG2, default 4, log2 of erase-block size in bytes; legal range 1..7.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 cmd_valid  input  1  host command request.
REQ-005 cmd_ready  output  1  controller idle, command accepted when cmd_valid&&cmd_ready at a rising edge.
REQ-006 cmd_op  input  2  0=READ, 1=PROGRAM, 2=ERASE, 3=reserved.
REQ-007 cmd_addr  input  8  byte address; block = cmd_addr[7:BLK_LOG2].
REQ-008 cmd_wdata  input  8  program data.
REQ-009 wp_n  input  1  write-protect, active-low; sampled at accept.
REQ-010 rsp_valid  output  1  one-cycle response pulse.
REQ-011 rsp_err  output  1  response error flag, valid with rsp_valid.
REQ-012 rsp_rdata  output  8  read data, valid with rsp_valid.
REQ-013 mem_we  output  1  memory write enable.
REQ-014 mem_re  output  1  memory read enable.
REQ-015 mem_addr  output  8  memory address.
REQ-016 mem_wdata  output  8  memory write data.
REQ-017 mem_rdata  input  8  memory read data, registered in memory: valid the cycle after the edge that sampled mem_re=1.

Function
REQ-018 FSM states SHALL be IDLE, RD_ISSUE, RD_WAIT, PG_READ, PG_WAIT, PG_WRITE, ER_WRITE, RESP.
REQ-019 cmd_ready SHALL be 1 only in IDLE; cmd_op/cmd_addr/cmd_wdata/wp_n SHALL be latched at the accept edge (E0).
REQ-020 mem_re SHALL be 1 only in RD_ISSUE and PG_READ; mem_we only in PG_WRITE and ER_WRITE; both never 1 simultaneously.
REQ-021 mem_addr/mem_wdata SHALL be 0 whenever mem_we and mem_re are both 0.
REQ-022 READ: E0->RD_ISSUE (mem_re=1, mem_addr=addr), E1->RD_WAIT, E2 captures mem_rdata->RESP; rsp_valid=1 during the cycle after E2, rsp_err=0.
REQ-023 PROGRAM: E0->PG_READ, E1->PG_WAIT, E2 captures old=mem_rdata.
REQ-024 PROGRAM legality: if (~old & wdata)!=0 (0->1 bit transition) SHALL go E2->RESP with rsp_err=1 and no write issued.
REQ-025 PROGRAM legal: E2->PG_WRITE (mem_we=1, mem_wdata=old & wdata), E3->RESP, rsp_err=0.
REQ-026 ERASE: E0->ER_WRITE with 2^BLK_LOG2 consecutive cycles, mem_we=1, mem_wdata=8'hFF, mem_addr={block, cnt}, cnt 0 to 2^BLK_LOG2-1; edge after last write->RESP, rsp_err=0.
REQ-027 cmd_op=3, or PROGRAM/ERASE with latched wp_n=0: E0->RESP, rsp_err=1, no memory access.
REQ-028 rsp_rdata SHALL equal captured data for READ and 8'h00 for every other response, including errors.
REQ-029 RESP SHALL last exactly one cycle and return to IDLE; back-to-back commands accepted the cycle after RESP.
REQ-030 cmd_valid while cmd_ready=0 SHALL be ignored, with no queuing.
REQ-031 Erase counter SHALL not wrap into the next block; addresses outside the latched block are never written.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE and counters to 0; cmd_ready=0 while in reset, 1 after release.
REQ-033 During reset, rsp_valid, rsp_err, rsp_rdata, mem_we, mem_re, mem_addr and mem_wdata SHALL be 0.
REQ-034 Reset mid-ERASE or mid-PROGRAM SHALL abort with no response; already-written bytes remain, no further writes.

Verification
REQ-035 ERASE addr 8'h10 (block 1), then READ 8'h13 -> 16 writes of FF to 8'h10..8'h1F; read rsp_rdata=8'hFF, rsp_err=0, rsp_valid the cycle after E2.
REQ-036 After erase, PROGRAM 8'h13 data 8'hAB, then READ 8'h13 -> mem_wdata=8'hAB at PG_WRITE; read returns 8'hAB.
REQ-037 PROGRAM 8'h13 data 8'hFF over 8'hAB -> rsp_err=1 after E2; mem_we never asserted; read still returns 8'hAB.
REQ-038 PROGRAM 8'h13 data 8'h03 -> legal, byte becomes 8'h03.
REQ-039 wp_n=0 with ERASE 8'h20, and cmd_op=3 -> rsp_err=1 cycle after accept, no mem_we/mem_re pulses.
REQ-040 rst_n low at cycle 5 of ERASE 8'h30, then READ 8'h36 -> no rsp_valid for the erase; 8'h30..8'h34 are FF, 8'h36 is unchanged.
